// File: rtl/gpr_wb_ctrl.sv
// Register-file write-port controller: ALU/LSU result arbitration,
// LSU result FIFO and destination-register scoreboard.
module gpr_wb_ctrl #(
   parameter int XLEN      = 64,
   parameter int LSU_DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [4:0]      issue_rs1,
   input  logic [4:0]      issue_rs2,
   input  logic [4:0]      issue_rd,
   input  logic            issue_wen,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_wdata,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_wdata,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] rd_wdata,
   output logic            reg_wen
);

   localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
   localparam int CW = $clog2(LSU_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(LSU_DEPTH);

   logic [31:0]      busy;
   logic [31:0]      busy_nxt;
   logic [4:0]       fifo_rd   [LSU_DEPTH];
   logic [XLEN-1:0]  fifo_data [LSU_DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             sel_alu;
   logic             sel_rd_nz;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;

   assign full  = (count == FULL);
   assign empty = (count == '0);

   assign issue_ready = !(busy[issue_rs1] || busy[issue_rs2] ||
                          (issue_wen && busy[issue_rd]));

   assign lsu_ready = !full;
   assign alu_ready = !full;

   // A full FIFO outranks the ALU so loads cannot starve.
   assign pop     = !empty && (full || !alu_valid);
   assign sel_alu = alu_valid && !full;
   assign push    = lsu_valid && lsu_ready;

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      unique case (1'b1)
         sel_alu: begin
            sel_rd   = alu_rd;
            sel_data = alu_wdata;
         end
         pop: begin
            sel_rd   = fifo_rd[rptr];
            sel_data = fifo_data[rptr];
         end
         default: ;
      endcase
   end

   assign sel_rd_nz = (sel_alu || pop) && (sel_rd != 5'd0);

   always_comb begin
      busy_nxt = busy;
      if (reg_wen)
         busy_nxt[rd] = 1'b0;
      if (issue_valid && issue_ready && issue_wen)
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_rd[wptr]   <= lsu_rd;
         fifo_data[wptr] <= lsu_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd       <= '0;
         rd_wdata <= '0;
         reg_wen  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (push)
            wptr <= wptr + PW'(1);
         if (pop)
            rptr <= rptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         if (sel_alu || pop) begin
            rd       <= sel_rd;
            rd_wdata <= sel_data;
         end
         reg_wen <= sel_rd_nz;
      end
   end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl.
// Inputs change 2 time units after each rising edge.
module tb_gpr_wb_ctrl;

   localparam int XLEN = 64;

   logic            clock;
   logic            reset;
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      issue_rs1;
   logic [4:0]      issue_rs2;
   logic [4:0]      issue_rd;
   logic            issue_wen;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_wdata;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_wdata;
   logic [4:0]      rd;
   logic [XLEN-1:0] rd_wdata;
   logic            reg_wen;

   int n_chk  = 0;
   int n_fail = 0;

   gpr_wb_ctrl #(.XLEN(XLEN), .LSU_DEPTH(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_wen   (issue_wen),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_wdata   (alu_wdata),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_wdata   (lsu_wdata),
      .rd          (rd),
      .rd_wdata    (rd_wdata),
      .reg_wen     (reg_wen)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic wr(input string tag, input logic wen,
                     input logic [4:0] r, input logic [63:0] d);
      chk({tag, ".wen"}, 64'(reg_wen), 64'(wen));
      if (wen) begin
         chk({tag, ".rd"}, 64'(rd), 64'(r));
         chk({tag, ".data"}, rd_wdata, d);
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
      issue_rd = 0; issue_wen = 0;
      alu_valid = 0; alu_rd = 0; alu_wdata = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
   endtask

   initial begin
      idle();
      reset = 0;
      #12;
      chk("rst.rd", 64'(rd), 0);
      chk("rst.data", rd_wdata, 0);
      chk("rst.wen", 64'(reg_wen), 0);
      chk("rst.issue_ready", 64'(issue_ready), 1);
      chk("rst.lsu_ready", 64'(lsu_ready), 1);
      chk("rst.alu_ready", 64'(alu_ready), 1);
      reset = 1;
      cyc();

      // ALU latency
      alu_valid = 1; alu_rd = 5; alu_wdata = 64'h1234;
      #1 chk("alu.ready", 64'(alu_ready), 1);
      cyc(); idle();
      wr("alu.n1", 1, 5, 64'h1234);
      cyc();
      wr("alu.n2", 0, 0, 0);

      // RAW / WAW stall on x7
      issue_valid = 1; issue_rd = 7; issue_wen = 1;
      #1 chk("raw.first", 64'(issue_ready), 1);
      cyc();
      issue_rs1 = 7; issue_rd = 8;
      #1 chk("raw.stall0", 64'(issue_ready), 0);
      cyc();
      chk("raw.stall1", 64'(issue_ready), 0);
      alu_valid = 1; alu_rd = 7; alu_wdata = 64'h77;
      #1 chk("raw.stall2", 64'(issue_ready), 0);
      cyc();
      alu_valid = 0;
      wr("raw.wb", 1, 7, 64'h77);
      chk("raw.stall_wb", 64'(issue_ready), 0);
      cyc();
      chk("raw.release", 64'(issue_ready), 1);
      cyc();
      idle();
      issue_rd = 8; issue_wen = 1;
      #1 chk("waw.stall", 64'(issue_ready), 0);
      issue_wen = 0;
      #1 chk("waw.nowen", 64'(issue_ready), 1);
      issue_rd = 0;
      issue_rs2 = 8;
      #1 chk("raw.rs2", 64'(issue_ready), 0);
      issue_rs2 = 0;

      // x0 results and issues
      alu_valid = 1; alu_rd = 0; alu_wdata = 64'hFFFF;
      #1 chk("x0.alu_ready", 64'(alu_ready), 1);
      cyc(); idle();
      chk("x0.nowen", 64'(reg_wen), 0);
      issue_valid = 1; issue_rd = 0; issue_wen = 1;
      #1 chk("x0.issue", 64'(issue_ready), 1);
      cyc(); idle();
      chk("x0.wen2", 64'(reg_wen), 0);
      issue_rs1 = 8;
      #1 chk("x0.sb_kept", 64'(issue_ready), 0);
      issue_rs1 = 0;

      // LSU latency
      lsu_valid = 1; lsu_rd = 4; lsu_wdata = 64'h44;
      #1 chk("lsu.ready", 64'(lsu_ready), 1);
      cyc(); idle();
      wr("lsu.n1", 0, 0, 0);
      cyc();
      wr("lsu.n2", 1, 4, 64'h44);
      cyc();

      // Collision
      alu_valid = 1; alu_rd = 1; alu_wdata = 64'hA;
      lsu_valid = 1; lsu_rd = 2; lsu_wdata = 64'hB;
      #1 chk("col.alu_ready", 64'(alu_ready), 1);
      chk("col.lsu_ready", 64'(lsu_ready), 1);
      cyc(); idle();
      wr("col.x1", 1, 1, 64'hA);
      cyc();
      wr("col.x2", 1, 2, 64'hB);
      cyc();
      wr("col.done", 0, 0, 0);
      chk("col.empty", 64'(lsu_ready), 1);

      // Starvation
      alu_valid = 1; alu_rd = 11; alu_wdata = 64'hB1;
      lsu_valid = 1; lsu_rd = 12; lsu_wdata = 64'hC1;
      cyc();
      alu_rd = 13; alu_wdata = 64'hB2;
      lsu_rd = 14; lsu_wdata = 64'hC2;
      #1 chk("stv.alu_ready1", 64'(alu_ready), 1);
      chk("stv.lsu_ready1", 64'(lsu_ready), 1);
      wr("stv.w11", 1, 11, 64'hB1);
      cyc();
      lsu_valid = 0;
      alu_rd = 15; alu_wdata = 64'hB3;
      #1 chk("stv.alu_block", 64'(alu_ready), 0);
      chk("stv.lsu_full", 64'(lsu_ready), 0);
      wr("stv.w13", 1, 13, 64'hB2);
      cyc();
      chk("stv.alu_ready3", 64'(alu_ready), 1);
      chk("stv.lsu_ready3", 64'(lsu_ready), 1);
      wr("stv.w12", 1, 12, 64'hC1);
      cyc();
      alu_valid = 0;
      wr("stv.w15", 1, 15, 64'hB3);
      cyc();
      wr("stv.w14", 1, 14, 64'hC2);
      cyc();
      wr("stv.done", 0, 0, 0);

      // Mid-operation reset with 2 FIFO entries and busy[3]
      issue_valid = 1; issue_rd = 3; issue_wen = 1;
      alu_valid = 1; alu_rd = 9; alu_wdata = 64'h99;
      lsu_valid = 1; lsu_rd = 20; lsu_wdata = 64'h2020;
      cyc();
      issue_valid = 0; issue_wen = 0; issue_rd = 0;
      alu_rd = 10; alu_wdata = 64'h1010;
      lsu_rd = 21; lsu_wdata = 64'h2121;
      cyc(); idle();
      issue_rs1 = 3;
      #1 chk("mrst.busy3", 64'(issue_ready), 0);
      chk("mrst.full", 64'(lsu_ready), 0);
      wr("mrst.pre", 1, 10, 64'h1010);
      reset = 0;
      #1 chk("mrst.wen", 64'(reg_wen), 0);
      chk("mrst.rd", 64'(rd), 0);
      chk("mrst.data", rd_wdata, 0);
      chk("mrst.lsu_ready", 64'(lsu_ready), 1);
      chk("mrst.alu_ready", 64'(alu_ready), 1);
      chk("mrst.issue", 64'(issue_ready), 1);
      cyc();
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("post.nowen", 64'(reg_wen), 0);
         chk("post.issue", 64'(issue_ready), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Write-side controller for the NPC general-purpose register file: it collects results from the ALU and the load/store unit, arbitrates them onto the single register-file write port (rd, rd_wdata, reg_wen), and tracks in-flight destination registers in a scoreboard. The scoreboard stalls issue until any pending producer of a source or destination register has written back. It sits between the execute/memory stages and the register file's write port, and drives the issue-stage stall.

## Interface
Parameters:
- XLEN, 64, data width of results and write port
- LSU_DEPTH, 2, depth of the LSU result FIFO (power of two, >= 2)

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- issue_valid  input  1  an instruction is presented for issue
- issue_ready  output  1  issue may proceed; no hazard on rs1/rs2/rd
- issue_rs1  input  5  source register 1 (0 = unused/x0)
- issue_rs2  input  5  source register 2 (0 = unused/x0)
- issue_rd  input  5  destination register
- issue_wen  input  1  instruction writes issue_rd
- alu_valid  input  1  ALU result present
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  5  ALU destination
- alu_wdata  input  XLEN  ALU result
- lsu_valid  input  1  load result present
- lsu_ready  output  1  LSU FIFO has space
- lsu_rd  input  5  load destination
- lsu_wdata  input  XLEN  load data
- rd  output  5  register-file write index
- rd_wdata  output  XLEN  register-file write data
- reg_wen  output  1  register-file write enable

## Operation
- Scoreboard: busy[31:1], bit 0 hard-wired 0.
  - Set busy[issue_rd] on an issue handshake (issue_valid && issue_ready) when issue_wen && issue_rd != 0.
  - Clear busy[rd] in any cycle where reg_wen = 1.
  - A set and clear of the same index in one cycle cannot occur, because issue stalls on a busy rd.
- issue_ready = !(busy[issue_rs1] || busy[issue_rs2] || (issue_wen && busy[issue_rd])).
  - Purely combinational; does not depend on issue_valid.
  - Covers RAW and WAW hazards. No bypass is provided.
- LSU FIFO: LSU_DEPTH entries of {rd, wdata}.
  - lsu_ready = (count < LSU_DEPTH), computed from registered count only; a same-cycle pop does not free space.
  - Push on lsu_valid && lsu_ready.
- Arbitration (selects the source for the output register each cycle):
  - FIFO full and non-empty: FIFO head wins; alu_ready = 0. This is the anti-starvation rule.
  - Otherwise, alu_valid: ALU wins; alu_ready = 1; the FIFO is not popped.
  - Otherwise, FIFO non-empty: pop the head.
  - Otherwise: no selection.
  - alu_ready = !(count == LSU_DEPTH).
- Output register: the selected result loads {rd, rd_wdata}; reg_wen = 1 only if a selection was made and its rd != 0. Results targeting x0 are consumed and dropped: reg_wen = 0, no scoreboard change.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo LSU_DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release on clock):
  - busy = 0, FIFO count = 0, pointers = 0.
  - rd = 0, rd_wdata = 0, reg_wen = 0.
  - issue_ready = 1, lsu_ready = 1, alu_ready = 1.
- Reset asserted mid-operation discards all FIFO contents and scoreboard bits immediately; no write is emitted afterwards.
- Latency:
  - Accepted ALU result in cycle N: reg_wen high in N+1; the register file is written at the end of N+1.
  - LSU result pushed in cycle N with the FIFO otherwise idle: popped in N+1, reg_wen high in N+2.
- Busy clears at the end of the reg_wen cycle. A dependent instruction stalled on that register sees issue_ready = 1 in the following cycle and reads the updated value.
- At most one register-file write per cycle. reg_wen is a single-cycle pulse per result.

## Test plan
- Reset, then ALU result rd = 5, data = 0x1234 in cycle 1 → reg_wen = 1, rd = 5, rd_wdata = 0x1234 in cycle 2; reg_wen = 0 in cycle 3.
- RAW stall: issue rd = 7 (wen) accepted; next issue rs1 = 7 → issue_ready = 0 until the ALU result for x7 is written with reg_wen; issue_ready = 1 the cycle after.
- Collision: alu_valid (rd = 1, 0xA) and lsu_valid (rd = 2, 0xB) in the same cycle with an empty FIFO → x1 written first, x2 written the next cycle, FIFO count returns to 0.
- Starvation: ALU valid every cycle while 2 loads arrive → FIFO full, alu_ready = 0 for one cycle, the LSU head is written; lsu_ready reasserts the following cycle.
- x0: ALU result rd = 0, data = 0xFFFF → alu_ready = 1, reg_wen stays 0, scoreboard unchanged; issue with rd = 0 is never stalled.
- Reset asserted with 2 FIFO entries and busy[3] set → outputs zero immediately; after release, no write occurs and an issue with rs1 = 3 gets issue_ready = 1.
